fixed_range_reduction_iter: RTL and testbench

Iterative range-reduction front end for the fixed-point inverse-square-root datapath. It accepts an unsigned fixed-point operand and locates its most-significant set bit by shifting one position per cycle. It returns the operand normalised to Q1.(WIDTH-1), in [1,2), together with the MSB index. Its outputs are in exactly the form the range-augmentation stage consumes after the core approximation. Valid/ready handshakes are used on both sides, and the block processes one operand at a time.

---
 rtl/fixed_range_reduction_iter.sv | 145 ++++++++++++++
 tb/tb_fixed_range_reduction_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_range_reduction_iter.sv
// Range-reduction front end for the inverse-square-root datapath.
// Finds the most-significant set bit of an unsigned operand. Returns the
// operand normalised to Q1.(WIDTH-1) together with the raw MSB index.
// Optional build macro FIXED_RANGE_REDUCTION_ITER_FAST_EN replaces the
// one-bit-per-cycle scan with a combinational leading-one detector.
module fixed_range_reduction_iter #(
    parameter int WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    localparam int MSB_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic [MSB_WIDTH-1:0] data_out_msb,
    output logic                 data_out_zero,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    // Reject parameter sets that cannot describe a sensible operand format.
    if (WIDTH < 2 || FRAC_WIDTH > WIDTH || FRAC_WIDTH < 0) begin : gBadParams
        $error("fixed_range_reduction_iter: invalid WIDTH/FRAC_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       dataOut_q, dataOut_d;
    logic [MSB_WIDTH-1:0]   msb_q, msb_d;
    logic                   zero_q, zero_d;

`ifdef FIXED_RANGE_REDUCTION_ITER_FAST_EN
    logic [MSB_WIDTH-1:0]   lodMsb;
    logic [WIDTH-1:0]       lodNorm;

    // Leading-one detector: the highest set bit wins, and the operand is shifted up to bit WIDTH-1.
    always_comb begin
        lodMsb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_in[i]) begin
                lodMsb = MSB_WIDTH'(i);
            end
        end
        lodNorm = data_in << (MSB_WIDTH'(WIDTH - 1) - lodMsb);
    end
`else
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [MSB_WIDTH-1:0]   count_q, count_d;
`endif

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        state_d   = state_q;
        dataOut_d = dataOut_q;
        msb_d     = msb_q;
        zero_d    = zero_q;
`ifndef FIXED_RANGE_REDUCTION_ITER_FAST_EN
        shift_d   = shift_q;
        count_d   = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    if (data_in == '0) begin
                        dataOut_d = '0;
                        msb_d     = '0;
                        zero_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        zero_d    = 1'b0;
`ifdef FIXED_RANGE_REDUCTION_ITER_FAST_EN
                        dataOut_d = lodNorm;
                        msb_d     = lodMsb;
                        state_d   = DONE;
`else
                        shift_d   = data_in;
                        count_d   = MSB_WIDTH'(WIDTH - 1);
                        state_d   = SCAN;
`endif
                    end
                end
            end
            SCAN: begin
`ifdef FIXED_RANGE_REDUCTION_ITER_FAST_EN
                state_d = IDLE;
`else
                // A nonzero operand always reaches bit WIDTH-1 before count hits zero.
                if (shift_q[WIDTH-1]) begin
                    dataOut_d = shift_q;
                    msb_d     = count_q;
                    state_d   = DONE;
                end else begin
                    shift_d = shift_q << 1;
                    count_d = count_q - 1'b1;
                end
`endif
            end
            DONE: begin
                if (data_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset; a reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dataOut_q <= '0;
            msb_q     <= '0;
            zero_q    <= 1'b0;
`ifndef FIXED_RANGE_REDUCTION_ITER_FAST_EN
            shift_q   <= '0;
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dataOut_q <= dataOut_d;
            msb_q     <= msb_d;
            zero_q    <= zero_d;
`ifndef FIXED_RANGE_REDUCTION_ITER_FAST_EN
            shift_q   <= shift_d;
            count_q   <= count_d;
`endif
        end
    end

    assign data_in_ready  = (state_q == IDLE);
    assign data_out_valid = (state_q == DONE);
    assign data_out       = dataOut_q;
    assign data_out_msb   = msb_q;
    assign data_out_zero  = zero_q;

endmodule

// File: tb/tb_fixed_range_reduction_iter.sv
// Directed self-checking bench for fixed_range_reduction_iter (WIDTH=16, FRAC_WIDTH=8).
// Expected latencies follow FIXED_RANGE_REDUCTION_ITER_FAST_EN when it is defined.
module tb_fixed_range_reduction_iter;

    localparam int WIDTH = 16;
    localparam int MSB_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIDTH-1:0]     dataIn = '0;
    logic                 dataInValid = 1'b0;
    logic                 dataInReady;
    logic [WIDTH-1:0]     dataOut;
    logic [MSB_WIDTH-1:0] dataOutMsb;
    logic                 dataOutZero;
    logic                 dataOutValid;
    logic                 dataOutReady = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] expOut;
        int          expMsb;
        int          expZero;
        int          expLatIter;
    } vec_t;

    vec_t vecs[7];

    fixed_range_reduction_iter #(
        .WIDTH(WIDTH),
        .FRAC_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(dataIn),
        .data_in_valid(dataInValid),
        .data_in_ready(dataInReady),
        .data_out(dataOut),
        .data_out_msb(dataOutMsb),
        .data_out_zero(dataOutZero),
        .data_out_valid(dataOutValid),
        .data_out_ready(dataOutReady)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int expectedLatency(input int latIter);
`ifdef FIXED_RANGE_REDUCTION_ITER_FAST_EN
        return 1;
`else
        return latIter;
`endif
    endfunction

    // Present one operand, let it be accepted and count cycles until valid (bounded).
    task automatic applyStimulus(input logic [15:0] din, output int lat);
        @(negedge clk);
        dataIn = din;
        dataInValid = 1'b1;
        dataOutReady = 1'b0;
        @(posedge clk);
        #1;
        dataInValid = 1'b0;
        lat = 1;
        while (!dataOutValid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Perform the output handshake and confirm the block is ready again on the next cycle.
    task automatic completeHandshake(input string tag);
        @(negedge clk);
        dataOutReady = 1'b1;
        @(posedge clk);
        #1;
        dataOutReady = 1'b0;
        checkOutput({tag, "_valid_after_hs"}, 32'(dataOutValid), 32'd0);
        checkOutput({tag, "_ready_after_hs"}, 32'(dataInReady), 32'd1);
    endtask

    task automatic checkResult(input string tag, input vec_t v, input int lat);
        checkOutput({tag, "_out"}, 32'(dataOut), 32'(v.expOut));
        checkOutput({tag, "_msb"}, 32'(dataOutMsb), 32'(v.expMsb));
        checkOutput({tag, "_zero"}, 32'(dataOutZero), 32'(v.expZero));
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expectedLatency(v.expLatIter)));
    endtask

    // Hard watchdog in case the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int spurious;
        logic [15:0] heldOut;

        vecs[0] = '{16'h0100, 16'h8000, 8,  0, 9};
        vecs[1] = '{16'h0300, 16'hC000, 9,  0, 8};
        vecs[2] = '{16'h8000, 16'h8000, 15, 0, 2};
        vecs[3] = '{16'h0001, 16'h8000, 0,  0, 17};
        vecs[4] = '{16'h0000, 16'h0000, 0,  1, 1};
        vecs[5] = '{16'h00B5, 16'hB500, 7,  0, 10};
        vecs[6] = '{16'h7FFF, 16'hFFFE, 14, 0, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(dataInReady), 32'd1);
        checkOutput("reset_valid", 32'(dataOutValid), 32'd0);
        checkOutput("reset_out", 32'(dataOut), 32'd0);
        checkOutput("reset_msb", 32'(dataOutMsb), 32'd0);
        checkOutput("reset_zero", 32'(dataOutZero), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].din, lat);
            checkResult($sformatf("vec%0d", i), vecs[i], lat);
            completeHandshake($sformatf("vec%0d", i));
        end

        // Backpressure: hold ready low in DONE and poke data_in_valid once.
        applyStimulus(16'h0300, lat);
        checkResult("bp", vecs[1], lat);
        heldOut = dataOut;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dataIn = 16'h1234;
            dataInValid = (c == 2);
            @(posedge clk);
            #1;
            dataInValid = 1'b0;
            checkOutput($sformatf("bp_valid_c%0d", c), 32'(dataOutValid), 32'd1);
            checkOutput($sformatf("bp_out_c%0d", c), 32'(dataOut), 32'(heldOut));
            checkOutput($sformatf("bp_msb_c%0d", c), 32'(dataOutMsb), 32'd9);
            checkOutput($sformatf("bp_inready_c%0d", c), 32'(dataInReady), 32'd0);
        end
        completeHandshake("bp");

        // Next operand offered on the very next cycle after the handshake.
        applyStimulus(16'h0100, lat);
        checkResult("bp_next", vecs[0], lat);
        completeHandshake("bp_next");

        // Reset during the 0x0001 transaction: it must be discarded.
        @(negedge clk);
        dataIn = 16'h0001;
        dataInValid = 1'b1;
        @(posedge clk);
        #1;
        dataInValid = 1'b0;
        checkOutput("rst_mid_accepted", 32'(dataInReady), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_valid", 32'(dataOutValid), 32'd0);
        checkOutput("rst_mid_ready", 32'(dataInReady), 32'd1);
        checkOutput("rst_mid_out", 32'(dataOut), 32'd0);
        checkOutput("rst_mid_msb", 32'(dataOutMsb), 32'd0);
        checkOutput("rst_mid_zero", 32'(dataOutZero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dataOutReady = 1'b1;
        spurious = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (dataOutValid || !dataInReady) spurious++;
        end
        dataOutReady = 1'b0;
        checkOutput("rst_mid_no_spurious", 32'(spurious), 32'd0);

        // Block still works after the aborted transaction.
        applyStimulus(16'h8000, lat);
        checkResult("post_rst", vecs[2], lat);
        completeHandshake("post_rst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
